// File: rtl/bus_timeout_counter.sv
// Bus transaction watchdog: counts edges with reset low and raises a sticky timeout.
// Define TIMEOUT_CNT_OUT_EN to expose the internal count on the count port.
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT = 10,
  localparam int unsigned CNT_W  = ($clog2(TIMEOUT + 1) > 1) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic             timeout
`ifdef TIMEOUT_CNT_OUT_EN
  ,
  output logic [CNT_W-1:0] count
`endif
);

  // A zero TIMEOUT behaves as one so the flag can never be high out of reset.
  localparam int unsigned TEFF = (TIMEOUT == 0) ? 1 : TIMEOUT;
  localparam logic [CNT_W:0] TEFF_X = (CNT_W + 1)'(TEFF);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic [CNT_W:0]   w_cnt_inc;
  logic             w_at_limit;
  logic             w_expire;

  always_comb begin
    w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    w_at_limit = ({1'b0, r_cnt} == TEFF_X);
    w_expire   = (w_cnt_inc >= TEFF_X);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_at_limit) begin
        r_cnt <= w_cnt_inc[CNT_W-1:0];
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout = r_timeout;

`ifdef TIMEOUT_CNT_OUT_EN
  assign count = r_cnt;
`endif

endmodule

// File: tb/tb_bus_timeout_counter.sv
// Bench for bus_timeout_counter: three instances (TIMEOUT=10, 0, 1) checked against
// a model that tracks consecutive low-reset edges since the last reset edge.
module tb_bus_timeout_counter;

  logic clk;
  logic rst10, rst0, rst1;
  logic to10, to0, to1;
`ifdef TIMEOUT_CNT_OUT_EN
  logic [3:0] cnt10;
  logic       cnt0;
  logic       cnt1;
`endif

  int unsigned tests;
  int unsigned fails;
  int unsigned n10, n0, n1;

  bus_timeout_counter #(.TIMEOUT(10)) u_dut10 (
    .clk    (clk),
    .reset  (rst10),
    .timeout(to10)
`ifdef TIMEOUT_CNT_OUT_EN
    ,
    .count  (cnt10)
`endif
  );

  bus_timeout_counter #(.TIMEOUT(0)) u_dut0 (
    .clk    (clk),
    .reset  (rst0),
    .timeout(to0)
`ifdef TIMEOUT_CNT_OUT_EN
    ,
    .count  (cnt0)
`endif
  );

  bus_timeout_counter #(.TIMEOUT(1)) u_dut1 (
    .clk    (clk),
    .reset  (rst1),
    .timeout(to1)
`ifdef TIMEOUT_CNT_OUT_EN
    ,
    .count  (cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned next_n(input int unsigned n, input logic rst);
    if (rst) return 0;
    return (n < 1000) ? n + 1 : n;
  endfunction

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  // Drive resets, take one edge, advance the model, then sample 1 time unit later.
  task automatic step(input logic r10, input logic r0, input logic r1);
    rst10 = r10;
    rst0  = r0;
    rst1  = r1;
    @(posedge clk);
    n10 = next_n(n10, r10);
    n0  = next_n(n0, r0);
    n1  = next_n(n1, r1);
    #1;
    chk("timeout_t10", 32'(to10), 32'(n10 >= 10));
    chk("timeout_t0",  32'(to0),  32'(n0 >= 1));
    chk("timeout_t1",  32'(to1),  32'(n1 >= 1));
`ifdef TIMEOUT_CNT_OUT_EN
    chk("count_t10", 32'(cnt10), min_u(n10, 10));
    chk("count_t0",  32'(cnt0),  min_u(n0, 1));
    chk("count_t1",  32'(cnt1),  min_u(n1, 1));
`endif
  endtask

  task automatic step_all(input logic r);
    step(r, r, r);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    n10   = 0;
    n0    = 0;
    n1    = 0;
    rst10 = 1'b1;
    rst0  = 1'b1;
    rst1  = 1'b1;

    // Reset held for three edges.
    for (int i = 0; i < 3; i++) step_all(1'b1);

    // Release: TIMEOUT=10 expires on edge 10; TIMEOUT=0/1 on edge 1.
    for (int i = 0; i < 12; i++) step_all(1'b0);

    // Reset mid-count restarts the full window.
    step_all(1'b1);
    for (int i = 0; i < 6; i++) step_all(1'b0);
    step_all(1'b1);
    for (int i = 0; i < 10; i++) step_all(1'b0);

    // Saturation: stays expired for a long hold.
    for (int i = 0; i < 50; i++) step_all(1'b0);

    // One-cycle reset after expiry, then re-expiry.
    step_all(1'b1);
    for (int i = 0; i < 11; i++) step_all(1'b0);

    // Reset lands on the edge that would expire.
    step_all(1'b1);
    for (int i = 0; i < 9; i++) step_all(1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_beats_expiry", 32'(to10), 32'd0);
    for (int i = 0; i < 3; i++) step_all(1'b0);

    // Random reset patterns, independent per instance, biased toward long low runs.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 13) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
